mpu_nested: RTL and testbench
=============================

# mpu_nested

Parametrised memory protection unit for the Hippomenes core, sitting between the load/store stage and data memory. It checks every load and store against a per-task region table held in CSRs, plus a stack window derived from a hardware LIFO of stack entry pointers. The LIFO tracks nested interrupt preemption to `NestDepth` levels. It raises a fault flag to the n-CLIC and, optionally, captures the faulting access for the handler.

## Interface
Parameters:
- `AddrWidth`, 16: data address width, ≤16
- `Tasks`, 9: number of region tables (8 interrupts + 1 memory exception)
- `Regions`, 4: regions per task
- `MaxDepth`, 'h100: stack window size in bytes
- `NestDepth`, 8: entry-pointer LIFO depth
- `CsrBase`, 'h400: first region CSR; fault-clear CSR is `CsrBase + Tasks*Regions`

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `addr` in AddrWidth: accessed address
- `sp` in AddrWidth: current stack pointer
- `op` in 7: instruction opcode; only LOAD 7'b0000011 and STORE 7'b0100011 are checked
- `interrupt_prio` in 8: current running priority
- `id` in 4: running task index, <Tasks
- `csr_enable`, `csr_addr`, `rs1_zimm`, `rs1_data`, `csr_op`: standard CSR write port
- `vcsr_addr`, `vcsr_width`, `vcsr_offset`: standard VCSR port
- `mem_fault_out` out 1: access denied this cycle
- `nest_overflow` out 1: sticky, LIFO push was dropped
- `fault_valid` out 1: captured fault pending
- `fault_addr` out AddrWidth: captured address
- `fault_id` out 4: captured task id
- `fault_is_store` out 1: captured op was a store

## Operation
- **Region CSR** `CsrBase + r + Regions*t`:
  - [31:16] base (low AddrWidth bits used)
  - [15:2] length in words
  - [1] write_en
  - [0] read_en
  - Covers base ≤ addr < base + (length<<2), computed at AddrWidth+1 bits with no wrap.
  - Length 0 disables the region.
- **Region match:** a LOAD passes if any covering region has read_en. A STORE passes if any covering region has write_en. Overlapping regions OR together.
- **Stack window:** passes if max(ep−MaxDepth, 0) ≤ addr < ep. ep = 0 gives an empty window.
- **Fault:** `mem_fault_out` = (op is LOAD or STORE) and no region passes and the stack window does not pass. All other ops give 0.
- **Entry LIFO:** holds `NestDepth` entries and a count; ep = top entry, or 0 when empty.
  - prio > last_prio: push sp; ep ← sp. When full, the push is dropped, ep is unchanged, and `nest_overflow` ← 1.
  - prio < last_prio: pop; ep ← new top (0 if empty). A pop when empty is ignored.
  - Equal prio: no change.
- **Active map:** `current_map` ← table[id] every cycle. `last_prio` ← interrupt_prio every cycle.
- **Fault capture:** when `mem_fault_out` = 1 and `fault_valid` = 0, latch addr, id and op; set `fault_valid`. Later faults do not overwrite.
  - Any CSR write to the fault-clear CSR clears `fault_valid`. If a new fault occurs in the same cycle, the new fault is captured and wins.
  - `nest_overflow` is also cleared by that write.
- **Reset:** LIFO empty, ep = 0, last_prio = 0, all CSRs 0.
  - All outputs 0.
  - Every load/store faults until regions are configured.
  - Reset mid-nest discards all entries.

## Timing
- The fault check is combinational from `addr`/`op` against registered ep and `current_map`. `mem_fault_out` is valid in the same cycle.
- A priority change at edge N takes effect on ep for accesses in cycle N+1. An access in the cycle where prio changes uses the old ep.
- A change of `id` takes effect on the map one cycle later. A CSR write takes effect two cycles later (CSR register, then `current_map`).
- Capture registers update at the edge ending the faulting cycle.

## Configuration
- `MPU_FAULT_CAPTURE_EN` defined: the capture registers and the fault-clear CSR are present.
- Undefined:
  - `fault_valid`, `fault_addr`, `fault_id`, `fault_is_store` are tied 0.
  - The fault-clear CSR address is unused.
  - `nest_overflow` is cleared only by reset.
  - `mem_fault_out` is unchanged.

## Test plan
- **Reset, no config:** LOAD addr 'h0010 → `mem_fault_out` = 1. Non-memory op → 0.
- **Region access control:** task 2 region 0 = base 'h2000, length 4 words, read only.
  - LOAD 'h200C → 0.
  - LOAD 'h2010 → 1.
  - STORE 'h2000 → 1.
- **Nesting:**
  - prio 0→3 with sp 'h8000: LOAD 'h7FF0 → 0, LOAD 'h7F00 → 0, LOAD 'h7EFF → 1.
  - prio 3→5 with sp 'h7E00: window becomes 'h7D00..'h7DFF.
  - prio 5→3: window restores to 'h7F00..'h7FFF.
- **Overflow:** 9 increasing prio steps with NestDepth = 8 → `nest_overflow` = 1 and ep stays at the 8th sp. 9 pops → ep = 0 and no hang.
- **Capture (EN):** faults at 'h1234 then 'h5678 → `fault_addr` = 'h1234.
  - Clear-CSR write → `fault_valid` = 0.
  - Clear in the same cycle as a fault at 'h9ABC → `fault_addr` = 'h9ABC, `fault_valid` = 1.
- **Same-cycle prio change:** prio rises in cycle N with an access inside the new window only → fault asserted in N; the same access in N+1 passes.

Source files
------------

// File: rtl/mpu_nested_if.sv
// Bus bundle between the load/store stage / CSR unit (master) and the nested MPU (slave).
interface mpu_nested_if #(
  parameter int AddrWidth = 16
);
  logic [AddrWidth-1:0] addr;
  logic [AddrWidth-1:0] sp;
  logic [6:0]           op;
  logic [7:0]           interrupt_prio;
  logic [3:0]           id;
  logic                 csr_enable;
  logic [11:0]          csr_addr;
  logic [4:0]           rs1_zimm;
  logic [31:0]          rs1_data;
  logic [2:0]           csr_op;
  logic [11:0]          vcsr_addr;
  logic [5:0]           vcsr_width;
  logic [4:0]           vcsr_offset;
  logic                 mem_fault_out;
  logic                 nest_overflow;
  logic                 fault_valid;
  logic [AddrWidth-1:0] fault_addr;
  logic [3:0]           fault_id;
  logic                 fault_is_store;

  modport master (
    output addr, sp, op, interrupt_prio, id,
    output csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op,
    output vcsr_addr, vcsr_width, vcsr_offset,
    input  mem_fault_out, nest_overflow, fault_valid, fault_addr, fault_id, fault_is_store
  );

  modport slave (
    input  addr, sp, op, interrupt_prio, id,
    input  csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op,
    input  vcsr_addr, vcsr_width, vcsr_offset,
    output mem_fault_out, nest_overflow, fault_valid, fault_addr, fault_id, fault_is_store
  );
endinterface

// File: rtl/mpu_nested.sv
// Memory protection unit: per-task region table plus a stack window from a nested entry-pointer LIFO.
// Define MPU_FAULT_CAPTURE_EN to add fault capture registers and the fault-clear CSR.
module mpu_nested #(
  parameter int AddrWidth = 16,
  parameter int Tasks     = 9,
  parameter int Regions   = 4,
  parameter int MaxDepth  = 'h100,
  parameter int NestDepth = 8,
  parameter int CsrBase   = 'h400
) (
  input logic       clk,
  input logic       reset,
  mpu_nested_if.slave bus
);

  localparam int Slots = Tasks * Regions;
  localparam int CntW  = $clog2(NestDepth + 1);
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  logic [31:0]          csr_regs    [Slots];
  logic [31:0]          current_map [Regions];
  logic [AddrWidth-1:0] lifo        [NestDepth];
  logic [CntW-1:0]      depth;
  logic [7:0]           last_prio;
  logic                 overflow_q;

  logic [AddrWidth-1:0] ep;
  logic [31:0]          ep_ext, addr_ext, win_lo;
  logic                 is_load, is_store, region_pass, stack_pass, mem_fault;
  logic                 push, pop, full, fault_clear;

  logic                 csr_wide;
  logic [11:0]          csr_target;
  logic [31:0]          csr_src, field_mask, csr_mask, csr_bits;

  function automatic logic region_ok(input logic [31:0] w, input logic [AddrWidth-1:0] a,
                                     input logic st);
    logic [31:0] lo, hi;
    lo = 32'(w[16 +: AddrWidth]);
    hi = lo + {16'd0, w[15:2], 2'b00};
    return (w[15:2] != 14'd0) && (32'(a) >= lo) && (32'(a) < hi) && (st ? w[1] : w[0]);
  endfunction

  function automatic logic [31:0] csr_update(input logic [31:0] old, input logic [1:0] kind,
                                             input logic [31:0] mask, input logic [31:0] bits);
    case (kind)
      2'b01:   return (old & ~mask) | bits;
      2'b10:   return old | bits;
      2'b11:   return old & ~bits;
      default: return old;
    endcase
  endfunction

  assign is_load  = (bus.op == OpLoad);
  assign is_store = (bus.op == OpStore);

  always_comb begin
    ep = '0;
    for (int i = 0; i < NestDepth; i++)
      if (CntW'(i + 1) == depth) ep = lifo[i];
  end

  always_comb begin
    region_pass = 1'b0;
    for (int r = 0; r < Regions; r++)
      if (region_ok(current_map[r], bus.addr, is_store)) region_pass = 1'b1;
  end

  // Window bottom clamps at zero; ep = 0 yields an empty window.
  assign ep_ext     = 32'(ep);
  assign addr_ext   = 32'(bus.addr);
  assign win_lo     = (ep_ext > 32'(MaxDepth)) ? ep_ext - 32'(MaxDepth) : 32'd0;
  assign stack_pass = (addr_ext >= win_lo) && (addr_ext < ep_ext);
  assign mem_fault  = (is_load | is_store) & ~region_pass & ~stack_pass;

  assign bus.mem_fault_out = mem_fault;
  assign bus.nest_overflow = overflow_q;

  assign full = (depth == CntW'(NestDepth));
  assign push = (bus.interrupt_prio > last_prio);
  assign pop  = (bus.interrupt_prio < last_prio);

  // A nonzero vcsr_width turns the access into a field write at vcsr_addr.
  assign csr_wide   = (bus.vcsr_width != 6'd0);
  assign csr_target = csr_wide ? bus.vcsr_addr : bus.csr_addr;
  assign csr_src    = bus.csr_op[2] ? {27'd0, bus.rs1_zimm} : bus.rs1_data;
  assign field_mask = (bus.vcsr_width >= 6'd32) ? 32'hFFFF_FFFF
                                                : ((32'd1 << bus.vcsr_width) - 32'd1);
  assign csr_mask   = csr_wide ? (field_mask << bus.vcsr_offset) : 32'hFFFF_FFFF;
  assign csr_bits   = (csr_wide ? (csr_src << bus.vcsr_offset) : csr_src) & csr_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      depth      <= '0;
      last_prio  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NestDepth; i++) lifo[i] <= '0;
      for (int r = 0; r < Regions; r++) current_map[r] <= '0;
      for (int i = 0; i < Slots; i++) csr_regs[i] <= '0;
    end else begin
      last_prio <= bus.interrupt_prio;

      if (push) begin
        if (!full) begin
          for (int i = 0; i < NestDepth; i++)
            if (CntW'(i) == depth) lifo[i] <= bus.sp;
          depth <= depth + 1'b1;
        end
      end else if (pop && depth != '0) begin
        depth <= depth - 1'b1;
      end

      if (push && full)     overflow_q <= 1'b1;
      else if (fault_clear) overflow_q <= 1'b0;

      for (int r = 0; r < Regions; r++) current_map[r] <= '0;
      for (int t = 0; t < Tasks; t++)
        for (int r = 0; r < Regions; r++)
          if (bus.id == 4'(t)) current_map[r] <= csr_regs[t * Regions + r];

      for (int i = 0; i < Slots; i++)
        if (bus.csr_enable && csr_target == 12'(CsrBase + i))
          csr_regs[i] <= csr_update(csr_regs[i], bus.csr_op[1:0], csr_mask, csr_bits);
    end
  end

`ifdef MPU_FAULT_CAPTURE_EN
  localparam logic [11:0] ClearAddr = 12'(CsrBase + Slots);

  logic                 fault_valid_q, fault_is_store_q;
  logic [AddrWidth-1:0] fault_addr_q;
  logic [3:0]           fault_id_q;

  assign fault_clear = bus.csr_enable && (csr_target == ClearAddr);

  // A fault in the clearing cycle re-arms the capture with the new access.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid_q    <= 1'b0;
      fault_addr_q     <= '0;
      fault_id_q       <= '0;
      fault_is_store_q <= 1'b0;
    end else if (mem_fault && (!fault_valid_q || fault_clear)) begin
      fault_valid_q    <= 1'b1;
      fault_addr_q     <= bus.addr;
      fault_id_q       <= bus.id;
      fault_is_store_q <= is_store;
    end else if (fault_clear) begin
      fault_valid_q    <= 1'b0;
    end
  end

  assign bus.fault_valid    = fault_valid_q;
  assign bus.fault_addr     = fault_addr_q;
  assign bus.fault_id       = fault_id_q;
  assign bus.fault_is_store = fault_is_store_q;
`else
  assign fault_clear        = 1'b0;
  assign bus.fault_valid    = 1'b0;
  assign bus.fault_addr     = '0;
  assign bus.fault_id       = '0;
  assign bus.fault_is_store = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_nested.sv
// Self-checking bench for mpu_nested: directed vector tables, hand sequences, and a randomized model run.
module tb_mpu_nested;
  localparam int AW    = 16;
  localparam int TASKS = 9;
  localparam int REGS  = 4;
  localparam int MAXD  = 'h100;
  localparam int NEST  = 8;
  localparam int BASE  = 'h400;
  localparam int CLR   = BASE + TASKS * REGS;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011;
`ifdef MPU_FAULT_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mpu_nested_if #(.AddrWidth(AW)) bus ();

  mpu_nested #(
    .AddrWidth(AW), .Tasks(TASKS), .Regions(REGS), .MaxDepth(MAXD),
    .NestDepth(NEST), .CsrBase(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          grp;
    string       name;
    logic [6:0]  op;
    logic [15:0] addr;
    bit          exp;
  } vec_t;
  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_cfg [TASKS*REGS];
  logic [31:0] m_map [REGS];
  int          m_lifo[$];
  int          m_last;
  bit          m_ovf, m_fv, m_fst;
  int          m_fa, m_fid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void addv(input int g, input string n, input logic [6:0] op,
                               input logic [15:0] a, input bit e);
    vec_t v;
    v.grp = g; v.name = n; v.op = op; v.addr = a; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.op = OPIMM;
    bus.csr_enable = 1'b0;
    bus.vcsr_width = '0;
  endtask

  task automatic acc(input string name, input logic [6:0] op, input logic [15:0] a, input bit e);
    bus.op = op;
    bus.addr = a;
    #2;
    check(name, bus.mem_fault_out, e);
    tick();
  endtask

  task automatic run_group(input int g);
    foreach (vecs[i])
      if (vecs[i].grp == g) acc(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].exp);
  endtask

  task automatic csr_wr(input int a, input logic [31:0] d);
    bus.csr_enable = 1'b1;
    bus.csr_addr = 12'(a);
    bus.rs1_data = d;
    bus.csr_op = 3'b001;
    tick();
    bus.csr_enable = 1'b0;
  endtask

  task automatic reset_dut();
    idle();
    bus.interrupt_prio = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic void model_reset();
    foreach (m_cfg[i]) m_cfg[i] = '0;
    foreach (m_map[i]) m_map[i] = '0;
    m_lifo.delete();
    m_last = 0;
    m_ovf = 0; m_fv = 0; m_fst = 0; m_fa = 0; m_fid = 0;
  endfunction

  function automatic bit model_fault(input int op, input int a);
    bit ok;
    int ep, lo;
    ok = 0;
    if (op != int'(LOAD) && op != int'(STORE)) return 1'b0;
    foreach (m_map[r]) begin
      int b, l;
      bit perm;
      b = m_map[r][31:16];
      l = m_map[r][15:2] * 4;
      perm = (op == int'(STORE)) ? m_map[r][1] : m_map[r][0];
      if (l != 0 && a >= b && a < b + l && perm) ok = 1;
    end
    ep = (m_lifo.size() == 0) ? 0 : m_lifo[$];
    lo = (ep > MAXD) ? ep - MAXD : 0;
    if (a >= lo && a < ep) ok = 1;
    return !ok;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit f, clr, drop;
    int target, w, off, pr;
    logic [31:0] val, mask, bits;
    f = model_fault(bus.op, bus.addr);
    w = bus.vcsr_width;
    off = bus.vcsr_offset;
    target = (w != 0) ? int'(bus.vcsr_addr) : int'(bus.csr_addr);
    clr = CAP && bus.csr_enable && target == CLR;
    for (int r = 0; r < REGS; r++)
      m_map[r] = (bus.id < TASKS) ? m_cfg[bus.id * REGS + r] : 32'd0;
    if (CAP) begin
      if (f && (!m_fv || clr)) begin
        m_fv = 1; m_fa = bus.addr; m_fid = bus.id; m_fst = (bus.op == STORE);
      end else if (clr) begin
        m_fv = 0;
      end
    end
    pr = bus.interrupt_prio;
    drop = 0;
    if (pr > m_last) begin
      if (m_lifo.size() < NEST) m_lifo.push_back(int'(bus.sp));
      else drop = 1;
    end else if (pr < m_last && m_lifo.size() > 0) begin
      void'(m_lifo.pop_back());
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_last = pr;
    if (bus.csr_enable && target >= BASE && target < CLR) begin
      val = bus.csr_op[2] ? {27'd0, bus.rs1_zimm} : bus.rs1_data;
      if (w == 0) begin
        mask = 32'hFFFF_FFFF;
        bits = val;
      end else begin
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        mask = mask << off;
        bits = (val << off) & mask;
      end
      case (bus.csr_op[1:0])
        2'b01: m_cfg[target - BASE] = (m_cfg[target - BASE] & ~mask) | bits;
        2'b10: m_cfg[target - BASE] = m_cfg[target - BASE] | bits;
        2'b11: m_cfg[target - BASE] = m_cfg[target - BASE] & ~bits;
        default: ;
      endcase
    end
  endtask

  initial begin
    int pr;
    bus.addr = '0; bus.sp = '0; bus.op = OPIMM; bus.interrupt_prio = '0; bus.id = '0;
    bus.csr_enable = 1'b0; bus.csr_addr = '0; bus.rs1_zimm = '0; bus.rs1_data = '0;
    bus.csr_op = '0; bus.vcsr_addr = '0; bus.vcsr_width = '0; bus.vcsr_offset = '0;

    addv(1, "rgn_load_last",  LOAD,  16'h200C, 1'b0);
    addv(1, "rgn_load_end",   LOAD,  16'h2010, 1'b1);
    addv(1, "rgn_store_ro",   STORE, 16'h2000, 1'b1);
    addv(1, "rgn_load_base",  LOAD,  16'h2000, 1'b0);
    addv(1, "rgn_load_below", LOAD,  16'h1FFF, 1'b1);
    addv(1, "rgn_nonmem",     OPIMM, 16'h2010, 1'b0);
    addv(2, "nest1_top",      LOAD,  16'h7FF0, 1'b0);
    addv(2, "nest1_bottom",   LOAD,  16'h7F00, 1'b0);
    addv(2, "nest1_below",    LOAD,  16'h7EFF, 1'b1);
    addv(2, "nest1_at_ep",    LOAD,  16'h8000, 1'b1);
    addv(2, "nest1_store",    STORE, 16'h7F80, 1'b0);
    addv(3, "nest2_top",      LOAD,  16'h7DFF, 1'b0);
    addv(3, "nest2_bottom",   LOAD,  16'h7D00, 1'b0);
    addv(3, "nest2_below",    LOAD,  16'h7CFF, 1'b1);
    addv(3, "nest2_at_ep",    LOAD,  16'h7E00, 1'b1);
    addv(3, "nest2_old_win",  LOAD,  16'h7F00, 1'b1);
    addv(4, "nest3_bottom",   LOAD,  16'h7F00, 1'b0);
    addv(4, "nest3_top",      LOAD,  16'h7FFF, 1'b0);
    addv(4, "nest3_inner",    LOAD,  16'h7DFF, 1'b1);

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    check("rst_mem_fault", bus.mem_fault_out, 1'b0);
    check("rst_nest_ovf", bus.nest_overflow, 1'b0);
    check("rst_fault_valid", bus.fault_valid, 1'b0);
    check("rst_fault_addr", bus.fault_addr, 16'h0);
    check("rst_fault_id", bus.fault_id, 4'h0);
    check("rst_fault_store", bus.fault_is_store, 1'b0);
    acc("rst_load", LOAD, 16'h0010, 1'b1);
    acc("rst_nonmem", OPIMM, 16'h0010, 1'b0);
    acc("rst_store", STORE, 16'h2000, 1'b1);

    // Region: write latency, then access control
    bus.id = 4'd2;
    tick();
    bus.csr_enable = 1'b1; bus.csr_addr = 12'(BASE + 0 + REGS * 2);
    bus.rs1_data = 32'h2000_0011; bus.csr_op = 3'b001;
    bus.op = LOAD; bus.addr = 16'h200C;
    #2; check("csr_lat0", bus.mem_fault_out, 1'b1);
    tick();
    bus.csr_enable = 1'b0;
    #2; check("csr_lat1", bus.mem_fault_out, 1'b1);
    tick();
    #2; check("csr_lat2", bus.mem_fault_out, 1'b0);
    tick();
    run_group(1);

    bus.id = 4'd3;
    acc("id_same_cycle", LOAD, 16'h2000, 1'b0);
    acc("id_next_cycle", LOAD, 16'h2000, 1'b1);
    bus.id = 4'd2;
    acc("id_back_same", LOAD, 16'h2000, 1'b1);
    acc("id_back_next", LOAD, 16'h2000, 1'b0);

    // Field write sets write_en only
    idle();
    bus.csr_enable = 1'b1; bus.csr_addr = 12'h000; bus.vcsr_addr = 12'(BASE + REGS * 2);
    bus.vcsr_width = 6'd1; bus.vcsr_offset = 5'd1; bus.rs1_data = 32'h1; bus.csr_op = 3'b001;
    tick();
    idle();
    acc("vcsr_lat1", STORE, 16'h2000, 1'b1);
    acc("vcsr_store", STORE, 16'h2000, 1'b0);
    acc("vcsr_keep_read", LOAD, 16'h200C, 1'b0);

    // Nesting
    bus.interrupt_prio = 8'd3; bus.sp = 16'h8000;
    acc("prio_same_cycle", LOAD, 16'h7FF0, 1'b1);
    run_group(2);
    bus.interrupt_prio = 8'd5; bus.sp = 16'h7E00;
    acc("push2_old_ep", LOAD, 16'h7F00, 1'b0);
    run_group(3);
    bus.interrupt_prio = 8'd3;
    acc("pop_old_ep", LOAD, 16'h7D00, 1'b0);
    run_group(4);
    bus.interrupt_prio = 8'd0;
    acc("pop0_old_ep", LOAD, 16'h7F00, 1'b0);
    acc("pop0_empty", LOAD, 16'h7F00, 1'b1);

    // Reset mid-nest, then overflow
    bus.interrupt_prio = 8'd2; bus.sp = 16'h4000;
    idle();
    tick();
    acc("pre_rst_window", LOAD, 16'h3FFF, 1'b0);
    reset_dut();
    acc("rst_mid_nest", LOAD, 16'h3FFF, 1'b1);
    idle();
    for (int i = 1; i <= 9; i++) begin
      bus.interrupt_prio = 8'(i);
      bus.sp = 16'(i * 'h1000);
      tick();
    end
    check("ovf_set", bus.nest_overflow, 1'b1);
    acc("ovf_ep8_in", LOAD, 16'h7FFF, 1'b0);
    acc("ovf_ep9_out", LOAD, 16'h8FFF, 1'b1);
    acc("ovf_ep8_bottom", LOAD, 16'h7F00, 1'b0);
    acc("ovf_ep8_below", LOAD, 16'h7EFF, 1'b1);
    bus.interrupt_prio = 8'd8;
    tick();
    acc("pop1_in", LOAD, 16'h6FFF, 1'b0);
    acc("pop1_out", LOAD, 16'h7FFF, 1'b1);
    idle();
    for (int i = 7; i >= 0; i--) begin
      bus.interrupt_prio = 8'(i);
      tick();
    end
    acc("pop9_empty", LOAD, 16'h0FFF, 1'b1);
    acc("pop9_empty2", LOAD, 16'h0F00, 1'b1);
    check("ovf_sticky", bus.nest_overflow, 1'b1);
    idle();
    csr_wr(CLR, 32'h0);
    check("ovf_clear_write", bus.nest_overflow, CAP ? 1'b0 : 1'b1);

    // Fault capture
    reset_dut();
    bus.id = 4'd5;
    acc("cap_fault1", LOAD, 16'h1234, 1'b1);
    check("cap_valid1", bus.fault_valid, CAP);
    check("cap_addr1", bus.fault_addr, CAP ? 16'h1234 : 16'h0);
    check("cap_id1", bus.fault_id, CAP ? 4'd5 : 4'd0);
    check("cap_store1", bus.fault_is_store, 1'b0);
    acc("cap_fault2", STORE, 16'h5678, 1'b1);
    check("cap_keep_addr", bus.fault_addr, CAP ? 16'h1234 : 16'h0);
    check("cap_keep_store", bus.fault_is_store, 1'b0);
    idle();
    csr_wr(CLR, 32'h0);
    check("cap_cleared", bus.fault_valid, 1'b0);
    bus.id = 4'd6;
    bus.op = STORE; bus.addr = 16'h9ABC;
    bus.csr_enable = 1'b1; bus.csr_addr = 12'(CLR); bus.csr_op = 3'b001;
    #2; check("cap_clr_fault", bus.mem_fault_out, 1'b1);
    tick();
    idle();
    check("cap_clr_valid", bus.fault_valid, CAP);
    check("cap_clr_addr", bus.fault_addr, CAP ? 16'h9ABC : 16'h0);
    check("cap_clr_id", bus.fault_id, CAP ? 4'd6 : 4'd0);
    check("cap_clr_store", bus.fault_is_store, CAP);

    // Randomized run against the reference model
    reset_dut();
    model_reset();
    pr = 0;
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 4))
        0, 1:    bus.op = LOAD;
        2, 3:    bus.op = STORE;
        default: bus.op = 7'($urandom);
      endcase
      bus.addr = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 'h4000))
                                             : 16'($urandom_range('h5E00, 'hA100));
      bus.id = 4'($urandom_range(0, TASKS - 1));
      bus.sp = 16'($urandom_range('h6000, 'hA000));
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 2) == 0) pr = (pr > 0) ? pr - 1 : 0;
        else pr = (pr < 255) ? pr + 1 : 255;
      end
      bus.interrupt_prio = 8'(pr);
      bus.csr_enable = ($urandom_range(0, 5) == 0);
      bus.csr_addr = ($urandom_range(0, 9) == 0) ? 12'(CLR) : 12'(BASE + $urandom_range(0, TASKS * REGS - 1));
      bus.csr_op = 3'($urandom_range(0, 7));
      bus.rs1_zimm = 5'($urandom);
      bus.rs1_data = ($urandom_range(0, 3) == 0) ? $urandom
                     : {16'($urandom_range(0, 'h3000)), 14'($urandom_range(0, 'h3FF)), 2'($urandom)};
      bus.vcsr_width = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 33)) : 6'd0;
      bus.vcsr_offset = 5'($urandom);
      bus.vcsr_addr = 12'(BASE + $urandom_range(0, TASKS * REGS - 1));
      #2;
      check("rnd_fault", bus.mem_fault_out, model_fault(bus.op, bus.addr));
      model_step();
      tick();
      check("rnd_ovf", bus.nest_overflow, m_ovf);
      check("rnd_fv", bus.fault_valid, m_fv);
      check("rnd_faddr", bus.fault_addr, 32'(m_fa));
      check("rnd_fid", bus.fault_id, 32'(m_fid));
      check("rnd_fstore", bus.fault_is_store, m_fst);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
